// File: rtl/if_stage_sramlike_pkg.sv
// mycpu_fetch_pkg: shared widths, buffer-entry layout and redirect sources for the fetch stage
package mycpu_fetch_pkg;
    localparam int FS_TO_DS_BUS_WD = 65;
    localparam int BR_BUS_WD       = 33;
    localparam int FS_PC_LSB       = 0;
    localparam int FS_INST_LSB     = 32;
    localparam int FS_ADEF_BIT     = 64;

    typedef enum logic [1:0] {RD_NONE, RD_EX, RD_ERTN, RD_BR} redir_e;

    function automatic logic [FS_TO_DS_BUS_WD-1:0] fs_entry(input logic adef, input logic [31:0] inst, input logic [31:0] pc);
        logic [FS_TO_DS_BUS_WD-1:0] e;
        e = '0;
        e[FS_ADEF_BIT] = adef;
        e[FS_INST_LSB +: 32] = inst;
        e[FS_PC_LSB +: 32] = pc;
        return e;
    endfunction
endpackage

// File: rtl/if_stage_sramlike_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; a push while full is accepted when a pop happens in the same cycle
// Ports: clk, reset (async, active high), i_flush empties the FIFO, i_push/i_data write,
//        i_pop read, o_data head entry, o_count occupancy, o_empty.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_cnt;
    logic             w_push, w_pop;

    always_comb begin
        w_pop   = i_pop && r_cnt != '0;
        w_push  = i_push && (r_cnt != (AW+1)'(DEPTH) || w_pop);
        o_data  = r_mem[r_rp];
        o_count = r_cnt;
        o_empty = r_cnt == '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wp] <= i_data;
    end
endmodule

// File: rtl/if_stage_sramlike.sv
// if_stage_sramlike: pre-IF/IF fetch stage on an SRAM-like req/addr_ok/data_ok bus with an instruction buffer
// Ports: clk, reset (async, active high); ds_allowin; br_bus {taken, target}; ex_flush/ex_entry;
//        ertn_flush/era; fs_to_ds_valid/fs_to_ds_bus {adef, inst, pc} to ID; inst_sram_* bus
//        (write side tied off). IF_PERF_CNT_EN adds fetch_cnt and cancel_cnt.
module if_stage_sramlike
    import mycpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h1c000000,
    parameter int          IBUF_DEPTH = 4,
    parameter int          CNT_W      = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    input  logic                       ex_flush,
    input  logic [31:0]                ex_entry,
    input  logic                       ertn_flush,
    input  logic [31:0]                era,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]                fetch_cnt,
    output logic [31:0]                cancel_cnt
`endif
);
    localparam int IW = $clog2(IBUF_DEPTH) + 1;

    logic                       r_run, r_stall;
    logic [31:0]                r_fetch_pc;
    logic [CNT_W-1:0]           r_discard;
    logic [IW-1:0]              w_inflight, w_ibuf_cnt;
    logic                       w_tag_empty, w_ibuf_empty;
    logic [31:0]                w_tag_pc, w_target;
    logic [FS_TO_DS_BUS_WD-1:0] w_ibuf_head, w_ibuf_din;
    redir_e                     w_rd;
    logic                       w_redirect, w_req, w_acc, w_drop, w_resp_push, w_adef_push, w_ibuf_pop;
    logic [CNT_W+1:0]           w_occ;
    logic [CNT_W-1:0]           w_disc_add;

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    always_comb begin
        w_rd        = ex_flush ? RD_EX : ertn_flush ? RD_ERTN : br_bus[BR_BUS_WD-1] ? RD_BR : RD_NONE;
        w_redirect  = w_rd != RD_NONE;
        w_target    = w_rd == RD_EX ? ex_entry : w_rd == RD_ERTN ? era : br_bus[31:0];
        // Bus transactions still owed to us (live or stale) plus buffered ones never exceed
        // IBUF_DEPTH, so the in-flight and discard counters cannot wrap.
        w_occ       = (CNT_W+2)'(w_inflight) + (CNT_W+2)'(w_ibuf_cnt) + (CNT_W+2)'(r_discard);
        w_req       = r_run && !w_redirect && r_fetch_pc[1:0] == 2'b00 && w_occ < (CNT_W+2)'(IBUF_DEPTH);
        w_acc       = w_req && inst_sram_addr_ok;
        // A response arriving with a redirect belongs to a cancelled request.
        w_drop      = inst_sram_data_ok && (r_discard != '0 || w_redirect);
        w_resp_push = inst_sram_data_ok && !w_drop && !w_tag_empty;
        w_adef_push = r_run && !w_redirect && r_fetch_pc[1:0] != 2'b00 && !r_stall
                      && w_inflight == '0 && w_ibuf_cnt != IW'(IBUF_DEPTH);
        w_ibuf_din  = w_resp_push ? fs_entry(1'b0, inst_sram_rdata, w_tag_pc) : fs_entry(1'b1, 32'h0, r_fetch_pc);
        w_disc_add  = w_redirect ? CNT_W'(w_inflight) + CNT_W'(w_acc) : '0;
        fs_to_ds_valid = !w_ibuf_empty && !w_redirect;
        fs_to_ds_bus   = fs_to_ds_valid ? w_ibuf_head : '0;
        w_ibuf_pop     = fs_to_ds_valid && ds_allowin;
        inst_sram_req  = w_req;
        inst_sram_addr = w_req ? r_fetch_pc : 32'h0;
    end

    // The pc-tag FIFO occupancy is the in-flight request count.
    fetch_fifo #(.WIDTH(32), .DEPTH(IBUF_DEPTH)) u_tag (
        .clk(clk), .reset(reset), .i_flush(w_redirect), .i_push(w_acc), .i_pop(w_resp_push),
        .i_data(r_fetch_pc), .o_data(w_tag_pc), .o_count(w_inflight), .o_empty(w_tag_empty)
    );

    fetch_fifo #(.WIDTH(FS_TO_DS_BUS_WD), .DEPTH(IBUF_DEPTH)) u_ibuf (
        .clk(clk), .reset(reset), .i_flush(w_redirect), .i_push(w_resp_push || w_adef_push), .i_pop(w_ibuf_pop),
        .i_data(w_ibuf_din), .o_data(w_ibuf_head), .o_count(w_ibuf_cnt), .o_empty(w_ibuf_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run      <= 1'b0;
            r_stall    <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_discard  <= '0;
        end else begin
            r_run     <= 1'b1;
            r_discard <= r_discard + w_disc_add - CNT_W'(w_drop);
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_stall    <= 1'b0;
            end else begin
                if (w_acc) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_adef_push) r_stall <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_drop) assert (r_discard + w_disc_add != '0);
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt  <= 32'h0;
            cancel_cnt <= 32'h0;
        end else begin
            fetch_cnt  <= fetch_cnt + 32'(w_acc);
            cancel_cnt <= cancel_cnt + 32'(w_drop);
        end
    end
`endif
endmodule

// File: tb/tb_if_stage_sramlike.sv
// tb_if_stage_sramlike: directed vectors and corner sequences for if_stage_sramlike against an in-order bus model
module tb_if_stage_sramlike;
    logic        clk = 0, reset = 1, ds_allowin = 0;
    logic [32:0] br_bus = 0;
    logic        ex_flush = 0, ertn_flush = 0;
    logic [31:0] ex_entry = 0, era = 0;
    logic        fs_to_ds_valid, inst_sram_req, inst_sram_wr;
    logic [64:0] fs_to_ds_bus;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic        inst_sram_addr_ok = 1, inst_sram_data_ok;
    logic        hold = 0;
    logic [31:0] q[$];
    logic [64:0] got[$];
    int          n_acc = 0, n_vec = 0, n_bad = 0;

    typedef struct {
        logic        allow;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;
    vec_t tv [7];

    if_stage_sramlike dut (
        .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus),
        .ex_flush(ex_flush), .ex_entry(ex_entry), .ertn_flush(ertn_flush), .era(era),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [64:0] ent(input logic [31:0] pc);
        return {1'b0, f(pc), pc};
    endfunction

    // In-order bus: data_ok one cycle after addr_ok unless hold is set.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            inst_sram_data_ok <= 1'b0;
            inst_sram_rdata   <= 32'h0;
        end else begin
            if (inst_sram_data_ok) void'(q.pop_front());
            if (inst_sram_req && inst_sram_addr_ok) begin
                q.push_back(inst_sram_addr);
                n_acc++;
            end
            if (fs_to_ds_valid && ds_allowin) got.push_back(fs_to_ds_bus);
            inst_sram_data_ok <= !hold && q.size() != 0;
            inst_sram_rdata   <= q.size() != 0 ? f(q[0]) : 32'h0;
        end
    end

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; br_bus = 0; ex_flush = 0; ertn_flush = 0; hold = 0; ds_allowin = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, n0, t;
        tv[0] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
        tv[1] = '{1'b1, 1'b1, 32'h1c000000, 1'b0, 32'h0};
        tv[2] = '{1'b1, 1'b1, 32'h1c000004, 1'b0, 32'h0};
        tv[3] = '{1'b1, 1'b1, 32'h1c000008, 1'b1, 32'h1c000000};
        tv[4] = '{1'b1, 1'b1, 32'h1c00000c, 1'b1, 32'h1c000004};
        tv[5] = '{1'b1, 1'b1, 32'h1c000010, 1'b1, 32'h1c000008};
        tv[6] = '{1'b1, 1'b1, 32'h1c000014, 1'b1, 32'h1c00000c};

        // reset state and zero-bubble streaming
        do_reset();
        chk("tie wr", inst_sram_wr, 0);
        chk("tie size", inst_sram_size, 2);
        chk("tie wstrb", inst_sram_wstrb, 0);
        chk("tie wdata", inst_sram_wdata, 0);
        for (int i = 0; i < 7; i++) begin
            if (i != 0) @(negedge clk);
            ds_allowin = tv[i].allow;
            #1;
            chk($sformatf("t1[%0d] req", i), inst_sram_req, tv[i].req);
            chk($sformatf("t1[%0d] addr", i), inst_sram_addr, tv[i].addr);
            chk($sformatf("t1[%0d] valid", i), fs_to_ds_valid, tv[i].vld);
            chk($sformatf("t1[%0d] bus", i), fs_to_ds_bus, tv[i].vld ? ent(tv[i].pc) : 65'h0);
        end

        // branch with two requests outstanding
        do_reset();
        hold = 1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); br_bus = {1'b1, 32'h1c000100}; hold = 0; #1;
        chk("t2 redirect req", inst_sram_req, 0);
        chk("t2 redirect valid", fs_to_ds_valid, 0);
        @(negedge clk); br_bus = 0; #1;
        chk("t2 discard", dut.r_discard, 2);
        chk("t2 req", inst_sram_req, 1);
        chk("t2 addr", inst_sram_addr, 32'h1c000100);
        @(negedge clk); #1;
        chk("t2 stale valid", fs_to_ds_valid, 0);
        @(negedge clk); #1;
        chk("t2 discard drained", dut.r_discard, 0);
        chk("t2 still empty", fs_to_ds_valid, 0);
        @(negedge clk); #1;
        chk("t2 first valid", fs_to_ds_valid, 1);
        chk("t2 first bus", fs_to_ds_bus, ent(32'h1c000100));

        // backpressure
        do_reset();
        ds_allowin = 0;
        n0 = n_acc;
        repeat (10) @(negedge clk);
        #1;
        chk("t3 accepted", n_acc - n0, 4);
        chk("t3 req stalled", inst_sram_req, 0);
        chk("t3 head valid", fs_to_ds_valid, 1);
        chk("t3 head bus", fs_to_ds_bus, ent(32'h1c000000));
        base = got.size();
        ds_allowin = 1;
        t = 0;
        while (got.size() - base < 8 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("t3 delivered 8", got.size() - base >= 8, 1);
        if (got.size() - base >= 8)
            for (int i = 0; i < 8; i++)
                chk($sformatf("t3 got[%0d]", i), got[base + i], ent(32'h1c000000 + 32'(4 * i)));

        // misaligned target
        do_reset();
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); br_bus = {1'b1, 32'h1c000102}; base = got.size(); n0 = n_acc; #1;
        chk("t4 redirect req", inst_sram_req, 0);
        @(negedge clk); br_bus = 0; #1;
        chk("t4 adef req", inst_sram_req, 0);
        repeat (8) @(negedge clk);
        #1;
        chk("t4 no requests", n_acc - n0, 0);
        chk("t4 one entry", got.size() - base, 1);
        if (got.size() > base) chk("t4 adef entry", got[base], {1'b1, 32'h0, 32'h1c000102});

        // simultaneous redirects
        do_reset();
        repeat (4) begin @(negedge clk); #1; end
        @(negedge clk);
        ex_flush = 1; ex_entry = 32'h1c008000; ertn_flush = 1; era = 32'h1c004000; br_bus = {1'b1, 32'h1c000200};
        #1;
        chk("t5 redirect req", inst_sram_req, 0);
        chk("t5 redirect valid", fs_to_ds_valid, 0);
        @(negedge clk); ex_flush = 0; ertn_flush = 0; br_bus = 0; #1;
        chk("t5 req", inst_sram_req, 1);
        chk("t5 addr", inst_sram_addr, 32'h1c008000);

        // asynchronous reset mid-burst
        do_reset();
        repeat (4) begin @(negedge clk); #1; end
        chk("t6 pre valid", fs_to_ds_valid, 1);
        chk("t6 pre req", inst_sram_req, 1);
        @(negedge clk); #2; reset = 1; #1;
        chk("t6 req clr", inst_sram_req, 0);
        chk("t6 addr clr", inst_sram_addr, 0);
        chk("t6 valid clr", fs_to_ds_valid, 0);
        chk("t6 bus clr", fs_to_ds_bus, 0);
        @(negedge clk);
        @(negedge clk); reset = 0; #1;
        chk("t6 c0 req", inst_sram_req, 0);
        @(negedge clk); #1;
        chk("t6 c1 addr", inst_sram_addr, 32'h1c000000);
        chk("t6 c1 req", inst_sram_req, 1);
        @(negedge clk); #1;
        chk("t6 c2 addr", inst_sram_addr, 32'h1c000004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
